// File: rtl/packet_tx_scheduler.sv
// Transmit packet buffer arbiter: round-robin grant between key and audio writers,
// transmitter launch with per-owner header, and acknowledged key delivery with bounded retry.
module packet_tx_scheduler #(
    parameter logic [15:0] KEY_HDR   = 16'h0001,
    parameter logic [15:0] AUDIO_HDR = 16'h0002,
    parameter logic [15:0] ACK_HDR   = 16'h0003,
    parameter int          TIMEOUT   = 1023,
    parameter int          MAX_RETRY = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        key_req,
    input  logic        key_we,
    input  logic [3:0]  key_addr,
    input  logic [15:0] key_data,
    input  logic        key_done,
    output logic        key_gnt,
    input  logic        audio_req,
    input  logic        audio_we,
    input  logic [3:0]  audio_addr,
    input  logic [15:0] audio_data,
    input  logic        audio_done,
    output logic        audio_gnt,
    output logic        buf_we,
    output logic [3:0]  buf_addr,
    output logic [15:0] buf_data,
    output logic        tx_start,
    output logic [15:0] tx_header,
    input  logic        tx_busy,
    input  logic [15:0] incoming_packet_header,
    output logic        key_acked,
    output logic        tx_fail
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [9:0]         TIMEOUT_V   = 10'(TIMEOUT);
    localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        LAUNCH,
        SENDING,
        WAIT_ACK
    } state_t;

    state_t               state_reg, state_next;
    logic                 owner_key_reg, owner_key_next;
    logic                 favour_key_reg, favour_key_next;
    logic [RETRY_W-1:0]   retry_reg, retry_next;
    logic [9:0]           timer_reg, timer_next;
    logic                 key_gnt_reg, key_gnt_next;
    logic                 audio_gnt_reg, audio_gnt_next;
    logic                 tx_start_reg, tx_start_next;
    logic [15:0]          tx_header_reg, tx_header_next;
    logic                 key_acked_reg, key_acked_next;
    logic                 tx_fail_reg, tx_fail_next;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            owner_key_reg  <= 1'b0;
            favour_key_reg <= 1'b1;
            retry_reg      <= '0;
            timer_reg      <= '0;
            key_gnt_reg    <= 1'b0;
            audio_gnt_reg  <= 1'b0;
            tx_start_reg   <= 1'b0;
            tx_header_reg  <= '0;
            key_acked_reg  <= 1'b0;
            tx_fail_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_key_reg  <= owner_key_next;
            favour_key_reg <= favour_key_next;
            retry_reg      <= retry_next;
            timer_reg      <= timer_next;
            key_gnt_reg    <= key_gnt_next;
            audio_gnt_reg  <= audio_gnt_next;
            tx_start_reg   <= tx_start_next;
            tx_header_reg  <= tx_header_next;
            key_acked_reg  <= key_acked_next;
            tx_fail_reg    <= tx_fail_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_key_next  = owner_key_reg;
        favour_key_next = favour_key_reg;
        retry_next      = retry_reg;
        timer_next      = timer_reg;
        key_gnt_next    = key_gnt_reg;
        audio_gnt_next  = audio_gnt_reg;
        tx_start_next   = 1'b0;
        tx_header_next  = tx_header_reg;
        key_acked_next  = 1'b0;
        tx_fail_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                // After any grant the pointer favours the other writer.
                if (key_req && (!audio_req || favour_key_reg)) begin
                    key_gnt_next    = 1'b1;
                    owner_key_next  = 1'b1;
                    favour_key_next = 1'b0;
                    state_next      = FILL;
                end else if (audio_req) begin
                    audio_gnt_next  = 1'b1;
                    owner_key_next  = 1'b0;
                    favour_key_next = 1'b1;
                    state_next      = FILL;
                end
            end

            FILL: begin
                if (owner_key_reg) begin
                    if (key_done) begin
                        key_gnt_next   = 1'b0;
                        tx_start_next  = 1'b1;
                        tx_header_next = KEY_HDR;
                        state_next     = LAUNCH;
                    end else if (!key_req) begin
                        key_gnt_next = 1'b0;
                        state_next   = IDLE;
                    end
                end else begin
                    if (audio_done) begin
                        audio_gnt_next = 1'b0;
                        tx_start_next  = 1'b1;
                        tx_header_next = AUDIO_HDR;
                        state_next     = LAUNCH;
                    end else if (!audio_req) begin
                        audio_gnt_next = 1'b0;
                        state_next     = IDLE;
                    end
                end
            end

            LAUNCH: begin
                state_next = SENDING;
            end

            SENDING: begin
                if (!tx_busy) begin
                    if (owner_key_reg) begin
                        timer_next = '0;
                        state_next = WAIT_ACK;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            WAIT_ACK: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (incoming_packet_header == ACK_HDR) begin
                    key_acked_next = 1'b1;
                    retry_next     = '0;
                    state_next     = IDLE;
                end else if (timer_reg == TIMEOUT_V) begin
                    if (retry_reg < MAX_RETRY_V) begin
                        retry_next     = retry_reg + 1'b1;
                        tx_start_next  = 1'b1;
                        tx_header_next = KEY_HDR;
                        state_next     = LAUNCH;
                    end else begin
                        tx_fail_next = 1'b1;
                        retry_next   = '0;
                        state_next   = IDLE;
                    end
                end else begin
                    timer_next = timer_reg + 10'd1;
                end
            end

            default: begin
                state_next     = IDLE;
                key_gnt_next   = 1'b0;
                audio_gnt_next = 1'b0;
            end
        endcase
    end

    assign buf_we   = (key_gnt_reg & key_we) | (audio_gnt_reg & audio_we);
    assign buf_addr = ({4{key_gnt_reg}} & key_addr) | ({4{audio_gnt_reg}} & audio_addr);
    assign buf_data = ({16{key_gnt_reg}} & key_data) | ({16{audio_gnt_reg}} & audio_data);

    assign key_gnt   = key_gnt_reg;
    assign audio_gnt = audio_gnt_reg;
    assign tx_start  = tx_start_reg;
    assign tx_header = tx_header_reg;
    assign key_acked = key_acked_reg;
    assign tx_fail   = tx_fail_reg;

endmodule

// File: doc/packet_tx_scheduler.md
Name: packet_tx_scheduler

Overview:
- Shares the single 16-word x 16-bit transmit packet buffer between two writers: the key-exchange sender, which serialises the 256-bit curve output, and the audio packetiser.
- Grants buffer write access round-robin, muxes the granted writer onto the buffer port, then launches the transmitter with the matching header.
- Key packets must be acknowledged by the far end through an incoming packet header. Unacknowledged key packets are resent with bounded retry.

Parameters:
KEY_HDR, 16'h0001, header sent with key packets
AUDIO_HDR, 16'h0002, header sent with audio packets
ACK_HDR, 16'h0003, incoming header that acknowledges a key packet
TIMEOUT, 1023, cycles to wait in WAIT_ACK before a retry (10-bit timer)
MAX_RETRY, 3, resends allowed after the first key transmission

Ports:
clock  in  1  system clock
reset_n  in  1  reset; synchronous, active-low
key_req  in  1  key writer requests the buffer
key_we  in  1  key writer write enable
key_addr  in  4  key writer word address
key_data  in  16  key writer word
key_done  in  1  pulse: key writer finished filling the buffer
key_gnt  out  1  key writer owns the buffer
audio_req  in  1  audio writer requests the buffer
audio_we  in  1  audio writer write enable
audio_addr  in  4  audio writer word address
audio_data  in  16  audio writer word
audio_done  in  1  pulse: audio writer finished filling the buffer
audio_gnt  out  1  audio writer owns the buffer
buf_we  out  1  packet buffer write enable
buf_addr  out  4  packet buffer address
buf_data  out  16  packet buffer write data
tx_start  out  1  one-cycle launch pulse to the transmitter
tx_header  out  16  header for the current packet; stable from tx_start until the next launch
tx_busy  in  1  transmitter busy; transmitter must raise it the cycle after tx_start
incoming_packet_header  in  16  header of the last received packet
key_acked  out  1  pulse: key packet acknowledged
tx_fail  out  1  pulse: key packet retries exhausted

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; every registered output 0 (key_gnt, audio_gnt, tx_start, tx_header, key_acked, tx_fail).
  - Round-robin pointer favours key; retry count = 0; timer = 0.
  - Applies mid-operation too: grants drop at that edge and no pulse is emitted.
- buf_we, buf_addr, buf_data are combinational:
  - Granted writer's we/addr/data gated by its gnt.
  - All zero when no grant is held.
  - Writes from the non-granted writer are dropped.
- IDLE:
  - One requester: grant it at the next edge, go to FILL.
  - Both requesting: grant the side the pointer favours; pointer then flips to the other side.
  - Grant latency is one cycle from req.
- FILL:
  - Granted done=1: gnt drops at the next edge, go to LAUNCH.
  - Granted req drops before done: gnt drops, go to IDLE, nothing is transmitted (abort).
  - done from the non-granted side, or done in any other state: ignored.
- LAUNCH:
  - tx_start=1 for exactly one cycle; tx_header = KEY_HDR or AUDIO_HDR per owner; go to SENDING.
- SENDING:
  - Stay while tx_busy=1.
  - tx_busy=0: an audio packet goes to IDLE; a key packet goes to WAIT_ACK with timer cleared.
- WAIT_ACK:
  - incoming_packet_header==ACK_HDR: key_acked pulses one cycle, retry count cleared, go to IDLE.
  - Otherwise the timer increments.
  - Timer==TIMEOUT with retries<MAX_RETRY: retries++, go to LAUNCH. The buffer is not refilled and no grant is issued.
  - Timer==TIMEOUT with retries==MAX_RETRY: tx_fail pulses one cycle, retries cleared, go to IDLE.
  - Ack and timeout in the same cycle: ack wins.
- Requests arriving outside IDLE wait; req must be held by the writer until granted.
- Exactly one of key_gnt/audio_gnt at most, at all times.

Test Plan:
- Reset then key_req=1; write words 0..15 = 16'h5555; key_done pulse -> key_gnt high one cycle after req; buf_we mirrors key_we; tx_start one cycle with tx_header=16'h0001; tx_busy held 20 cycles; incoming_packet_header=16'h0003 -> key_acked one pulse, state IDLE.
- key_req and audio_req asserted together from reset -> key granted first; after key ack, audio_gnt next; audio tx ends at tx_busy fall with no WAIT_ACK; second simultaneous request -> key granted again (pointer alternates).
- Key packet, no ack -> tx_start repeats every TIMEOUT + busy time, 4 launches total (1 + MAX_RETRY), then tx_fail one pulse; key_acked never asserted.
- audio_we pulses while key_gnt=1 -> buf_we low for those cycles; buffer contents stay the key data.
- ACK_HDR arriving exactly at timer==TIMEOUT -> key_acked, no relaunch; reset_n=0 during SENDING -> all outputs 0 next edge, next key_req re-granted normally.
- key_req dropped mid-FILL without key_done -> key_gnt falls next edge, no tx_start.
